// File: rtl/dac_adc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dac_adc_pkg
//  Description : Shared types and constants for the ADS784x-style SPI ADC
//                responder: command layout, FSM state encoding and the
//                channel-select decode table.
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_adc_pkg;

    // Command word layout (as seen after all 8 bits have been shifted in)
    localparam int CMD_W         = 8;
    localparam int START_BIT_POS = 7;
    localparam int CH_FIELD_MSB  = 6;
    localparam int CH_FIELD_LSB  = 4;

    // Responder FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_BUSY   = 3'd2,
        ST_DATA   = 3'd3,
        ST_DONE   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    // Result of decoding the 3-bit channel field
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } chan_sel_t;

    // Channel field -> sample index; codes not listed are not channels we model
    function automatic chan_sel_t chan_map(input logic [2:0] a);
        chan_sel_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (a)
            3'b001:  r.idx = 2'd0;
            3'b101:  r.idx = 2'd1;
            3'b010:  r.idx = 2'd2;
            3'b110:  r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_responder_if.sv
`default_nettype none
// ============================================================================
//  Interface   : adc_spi_responder_if
//  Description : SPI pin bundle between the read master and the ADC
//                responder. The master drives cs/dclk/mosi, the responder
//                drives miso.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_spi_responder_if;

    logic cs_i;     // chip select, active low
    logic dclk_i;   // SPI clock, idle low
    logic mosi_i;   // command bits, valid at dclk rise
    logic miso_o;   // response bits, updated after dclk fall

    modport master (
        output cs_i,
        output dclk_i,
        output mosi_i,
        input  miso_o
    );

    modport slave (
        input  cs_i,
        input  dclk_i,
        input  mosi_i,
        output miso_o
    );

endinterface
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Multi-flop synchronizer for an asynchronous pin with
//                single-cycle rise/fall pulses derived from the synchronized
//                level. The reset value sets the idle level so that no
//                spurious edge is reported when reset is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic d_i,
    output logic      level_o,
    output logic      rise_o,
    output logic      fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer chain and keep one cycle of history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_responder
//  Description : Oversampled SPI responder emulating a 4-channel ADS784x
//                ADC. Receives an 8-bit command on mosi, answers with a busy
//                bit followed by a WIDTH-bit sample (MSB first) on miso.
//                All SPI pins are synchronized to clk_i; there is no SPI
//                clock domain inside.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_responder
    import dac_adc_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    adc_spi_responder_if.slave      spi,
    input  wire logic [NCH*WIDTH-1:0] samples_i,
    output logic [CMD_W-1:0]        cmd_o,
    output logic                    cmd_valid_o,
    output logic                    busy_o,
    output logic                    frame_err_o
);

    localparam int                DCNT_W       = $clog2(WIDTH + 1);
    localparam logic [2:0]        CMD_CNT_LAST = 3'(CMD_W - 1);
    localparam logic [DCNT_W-1:0] DATA_CNT_END = DCNT_W'(WIDTH);

    // ------------------------------------------------------------------
    // Pin synchronization and edge detection
    // ------------------------------------------------------------------
    logic w_cs_rise, w_cs_fall;
    logic w_dclk_rise, w_dclk_fall;
    logic w_mosi;
    logic w_cs_level_unused, w_dclk_level_unused;
    logic w_mosi_rise_unused, w_mosi_fall_unused;

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (spi.cs_i),
        .level_o (w_cs_level_unused),
        .rise_o  (w_cs_rise),
        .fall_o  (w_cs_fall)
    );

    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_dclk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (spi.dclk_i),
        .level_o (w_dclk_level_unused),
        .rise_o  (w_dclk_rise),
        .fall_o  (w_dclk_fall)
    );

    // mosi goes through the same depth as dclk so its level lines up with the dclk edge
    sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_mosi (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (spi.mosi_i),
        .level_o (w_mosi),
        .rise_o  (w_mosi_rise_unused),
        .fall_o  (w_mosi_fall_unused)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [2:0]         cmd_cnt_q,   cmd_cnt_d;
    logic [DCNT_W-1:0]  data_cnt_q,  data_cnt_d;
    logic [CMD_W-1:0]   cmd_sr_q,    cmd_sr_d;
    logic [WIDTH-1:0]   out_sr_q,    out_sr_d;
    logic               miso_q,      miso_d;
    logic [CMD_W-1:0]   cmd_q,       cmd_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               frame_err_q, frame_err_d;

    // Command register contents once the current mosi bit is shifted in
    logic [CMD_W-1:0]   w_cmd_shift;
    chan_sel_t          w_sel;
    logic [WIDTH-1:0]   w_sample;
    logic               w_ch_found;

    assign w_cmd_shift = {cmd_sr_q[CMD_W-2:0], w_mosi};

    // Decode the channel field and pick the matching sample from the input bus
    always_comb begin
        w_sel      = chan_map(w_cmd_shift[CH_FIELD_MSB:CH_FIELD_LSB]);
        w_sample   = '0;
        w_ch_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (w_sel.valid && (w_sel.idx == 2'(k))) begin
                w_sample   = samples_i[k*WIDTH +: WIDTH];
                w_ch_found = 1'b1;
            end
        end
    end

    // Next-state logic: cs rise overrides everything, including a dclk edge in the same cycle
    always_comb begin
        state_d     = state_q;
        cmd_cnt_d   = cmd_cnt_q;
        data_cnt_d  = data_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        out_sr_d    = out_sr_q;
        miso_d      = miso_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (w_cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            // Leaving before the sample was fully shifted out is an aborted frame
            if ((state_q == ST_CMD) || (state_q == ST_BUSY) || (state_q == ST_DATA)) begin
                frame_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (w_cs_fall) begin
                        state_d   = ST_CMD;
                        cmd_cnt_d = '0;
                        cmd_sr_d  = '0;
                    end
                end

                ST_CMD: begin
                    if (w_dclk_rise) begin
                        cmd_sr_d = w_cmd_shift;
                        // The first bit received ends up at START_BIT_POS and must be 1
                        if ((cmd_cnt_q == 3'd0) && !w_mosi) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_IGNORE;
                        end else if (cmd_cnt_q == CMD_CNT_LAST) begin
                            if (w_ch_found) begin
                                out_sr_d    = w_sample;
                                cmd_d       = w_cmd_shift;
                                cmd_valid_d = 1'b1;
                                state_d     = ST_BUSY;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = ST_IGNORE;
                            end
                        end else begin
                            cmd_cnt_d = cmd_cnt_q + 3'd1;
                        end
                    end
                end

                ST_BUSY: begin
                    if (w_dclk_fall) begin
                        miso_d     = 1'b0;
                        state_d    = ST_DATA;
                        data_cnt_d = '0;
                    end
                end

                ST_DATA: begin
                    if (w_dclk_fall) begin
                        if (data_cnt_q == DATA_CNT_END) begin
                            miso_d  = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            miso_d     = out_sr_q[WIDTH-1];
                            out_sr_d   = {out_sr_q[WIDTH-2:0], 1'b0};
                            data_cnt_d = data_cnt_q + DCNT_W'(1);
                        end
                    end
                end

                ST_DONE, ST_IGNORE: begin
                    miso_d = 1'b0;
                end

                default: begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // Register all state and outputs; reset returns everything to idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_cnt_q   <= '0;
            data_cnt_q  <= '0;
            cmd_sr_q    <= '0;
            out_sr_q    <= '0;
            miso_q      <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_cnt_q   <= cmd_cnt_d;
            data_cnt_q  <= data_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            out_sr_q    <= out_sr_d;
            miso_q      <= miso_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign spi.miso_o  = miso_q;
    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_IGNORE);

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_spi_responder
//  Description : Self-checking bench for adc_spi_responder. Acts as the SPI
//                read master and keeps a frame-level model (edge counts and
//                bit positions) that predicts every output cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_responder;

    localparam int WIDTH = 12;
    localparam int NCH   = 4;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + 1;   // pin change -> registered output

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NCH*WIDTH-1:0]   samples_v;
    logic [7:0]             cmd_o;
    logic                   cmd_valid_o, busy_o, frame_err_o;

    adc_spi_responder_if spi_if ();

    adc_spi_responder #(
        .WIDTH       (WIDTH),
        .NCH         (NCH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .spi         (spi_if),
        .samples_i   (samples_v),
        .cmd_o       (cmd_o),
        .cmd_valid_o (cmd_valid_o),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_err   = 0;

    // Pin events: 0 cs fall, 1 cs rise, 2 dclk rise, 3 dclk fall
    typedef struct {
        int   at;
        int   kind;
        logic mosi;
    } ev_t;
    ev_t evq[$];
    ev_t cur[$];
    bit  cs_seen;

    // Frame-level model
    bit          m_active, m_ignore, m_acc;
    int          m_rises, m_falls;
    logic [7:0]  m_sr;
    logic [11:0] m_sample;
    logic [7:0]  e_cmd;
    logic        e_valid, e_err, e_miso;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int chan_of(input logic [2:0] code);
        case (code)
            3'b001:  return 0;
            3'b101:  return 1;
            3'b010:  return 2;
            3'b110:  return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_active = 0; m_ignore = 0; m_acc = 0;
        m_rises = 0;  m_falls = 0;
        m_sr = '0;    m_sample = '0;
        e_cmd = '0;   e_miso = 1'b0;
    endtask

    task automatic apply_ev(input int kind, input logic mosi, input bit cs_now);
        int ch;
        case (kind)
            0: begin
                m_active = 1; m_ignore = 0; m_acc = 0;
                m_rises = 0;  m_falls = 0;  m_sr = '0;
            end
            1: begin
                if (m_active && !m_ignore && !(m_acc && m_falls >= WIDTH + 2)) e_err = 1'b1;
                m_active = 0; m_ignore = 0;
                e_miso = 1'b0;
            end
            2: if (!cs_now && m_active && !m_ignore && !m_acc) begin
                m_rises++;
                m_sr = {m_sr[6:0], mosi};
                if (m_rises == 1 && mosi == 1'b0) begin
                    e_err = 1'b1; m_ignore = 1;
                end else if (m_rises == 8) begin
                    ch = chan_of(m_sr[6:4]);
                    if (ch < 0) begin
                        e_err = 1'b1; m_ignore = 1;
                    end else begin
                        m_acc    = 1; m_falls = 0;
                        m_sample = samples_v[ch*WIDTH +: WIDTH];
                        e_cmd    = m_sr;
                        e_valid  = 1'b1;
                    end
                end
            end
            default: if (!cs_now && m_active && !m_ignore && m_acc) begin
                m_falls++;
                e_miso = (m_falls >= 2 && m_falls <= WIDTH + 1) ? m_sample[WIDTH + 1 - m_falls] : 1'b0;
            end
        endcase
    endtask

    // Advance the model at each active edge, then compare every output just after it
    always begin
        @(posedge clk);
        cyc++;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (rst) begin
            model_reset();
            evq.delete();
        end else begin
            cur.delete();
            while (evq.size() > 0 && evq[0].at <= cyc) cur.push_back(evq.pop_front());
            cs_seen = 0;
            foreach (cur[j]) if (cur[j].kind < 2) cs_seen = 1;
            foreach (cur[j]) apply_ev(cur[j].kind, cur[j].mosi, cs_seen);
        end
        #1;
        chk("cmd_o",       cmd_o,          e_cmd);
        chk("cmd_valid_o", cmd_valid_o,    e_valid);
        chk("busy_o",      busy_o,         m_active && !m_ignore);
        chk("frame_err_o", frame_err_o,    e_err);
        chk("miso_o",      spi_if.miso_o,  e_miso);
        if (cmd_valid_o === 1'b1) n_valid++;
        if (frame_err_o === 1'b1) n_err++;
    end

    // Stimulus helpers: all called right after a falling clock edge
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cs(input logic v);
        spi_if.cs_i = v;
        evq.push_back('{cyc + LAT, v ? 1 : 0, 1'b0});
    endtask

    task automatic set_dclk(input logic v);
        spi_if.dclk_i = v;
        evq.push_back('{cyc + LAT, v ? 2 : 3, spi_if.mosi_i});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        spi_if.cs_i = 1'b1; spi_if.dclk_i = 1'b0; spi_if.mosi_i = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(3);
    endtask

    // One master transaction of nclk dclk cycles; dout collects miso at rises 10..21
    task automatic frame(input logic [7:0] cmd, input int nclk, input int h,
                         input int chg_at, input int rst_at, input bit coinc,
                         output logic [11:0] dout, output int dv, output int de);
        int v0, e0;
        v0 = n_valid; e0 = n_err; dout = '0;
        spi_if.mosi_i = cmd[7];
        set_cs(1'b0);
        tick(h);
        for (int i = 1; i <= nclk; i++) begin
            if (i == rst_at) begin
                do_reset();
                dv = n_valid - v0; de = n_err - e0;
                return;
            end
            if (i == chg_at) samples_v[11:0] = 12'h123;
            if (i >= 10 && i <= 21) dout = {dout[10:0], spi_if.miso_o};
            set_dclk(1'b1);
            tick(h);
            set_dclk(1'b0);
            spi_if.mosi_i = (i < 8) ? cmd[7 - i] : 1'b0;
            tick(h);
        end
        if (coinc) begin
            set_dclk(1'b1);
            set_cs(1'b1);
            tick(h);
            set_dclk(1'b0);
        end else begin
            set_cs(1'b1);
        end
        tick(h + LAT + 3);
        dv = n_valid - v0; de = n_err - e0;
    endtask

    initial begin
        logic [11:0] d;
        int dv, de, v0, e0;
        spi_if.cs_i = 1'b1; spi_if.dclk_i = 1'b0; spi_if.mosi_i = 1'b0;
        samples_v = '0;
        tick(4);
        rst = 1'b0;
        tick(4);

        // dclk toggling with cs high must do nothing
        v0 = n_valid; e0 = n_err;
        repeat (10) begin set_dclk(1'b1); tick(5); set_dclk(1'b0); tick(5); end
        tick(LAT + 2);
        chk("idle_valid", n_valid - v0, 0);
        chk("idle_err",   n_err - e0,   0);
        chk("idle_cmd",   cmd_o,        8'h00);

        // basic read of channel 0
        samples_v = {12'h0AA, 12'h001, 12'hFFF, 12'h9B2};
        frame(8'h97, 21, 5, 0, 0, 0, d, dv, de);
        chk("f97_dout", d, 12'h9B2);  chk("f97_valid", dv, 1);
        chk("f97_err", de, 0);        chk("f97_cmd", cmd_o, 8'h97);

        frame(8'hD7, 21, 6, 0, 0, 0, d, dv, de);
        chk("fD7_dout", d, 12'hFFF);  chk("fD7_cmd", cmd_o, 8'hD7);
        frame(8'hA7, 22, 7, 0, 0, 0, d, dv, de);
        chk("fA7_dout", d, 12'h001);  chk("fA7_err", de, 0);

        // bad start bit and unmapped channel code
        frame(8'h17, 21, 5, 0, 0, 0, d, dv, de);
        chk("f17_dout", d, 12'h000);  chk("f17_err", de, 1);
        chk("f17_valid", dv, 0);      chk("f17_cmd_held", cmd_o, 8'hA7);
        frame(8'h87, 21, 5, 0, 0, 0, d, dv, de);
        chk("f87_err", de, 1);        chk("f87_valid", dv, 0);

        // abort after 5 data bits, then a clean frame
        frame(8'h97, 14, 5, 0, 0, 0, d, dv, de);
        chk("abort_err", de, 1);      chk("abort_bits", d[4:0], 5'b10011);
        frame(8'h97, 21, 5, 0, 0, 0, d, dv, de);
        chk("after_abort_dout", d, 12'h9B2); chk("after_abort_err", de, 0);

        // cs rise together with a dclk rise mid-data
        frame(8'h97, 14, 6, 0, 0, 1, d, dv, de);
        chk("coinc_err", de, 1);

        // sample change during the data phase does not affect the frame
        frame(8'h97, 21, 5, 12, 0, 0, d, dv, de);
        chk("hold_dout", d, 12'h9B2);
        frame(8'h97, 21, 5, 0, 0, 0, d, dv, de);
        chk("new_dout", d, 12'h123);

        // reset in the middle of the data phase
        frame(8'hD7, 21, 5, 0, 15, 0, d, dv, de);
        chk("rst_cmd", cmd_o, 8'h00); chk("rst_busy", busy_o, 1'b0);
        chk("rst_miso", spi_if.miso_o, 1'b0);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            logic [7:0] c;
            int n, hh, ch;
            bit cc;
            logic [11:0] es;
            samples_v = {16'($urandom()), $urandom()};
            c  = {1'b1, 3'($urandom()), 4'($urandom())};
            n  = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : $urandom_range(21, 24);
            hh = $urandom_range(SYNC + 3, SYNC + 6);
            cc = 1'($urandom());
            ch = chan_of(c[6:4]);
            es = (ch >= 0) ? samples_v[ch*WIDTH +: WIDTH] : 12'h000;
            frame(c, n, hh, 0, 0, cc, d, dv, de);
            chk("rnd_valid", dv, (ch >= 0 && n >= 8) ? 1 : 0);
            chk("rnd_err",   de, (n < 21) ? 1 : ((ch >= 0) ? 0 : 1));
            if (n >= 21) chk("rnd_dout", d, es);
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
